// File: rtl/truth_table_sweeper_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_pkg
//   Shared definitions for the truth-table sweeper:
//     - sweep_state_e      : FSM state encoding (IDLE / RUN / DONE)
//     - SWEEP_N_IN_DEFAULT : default number of DUT inputs
//     - SWEEP_EXPECTED_DEFAULT : default expected minterm mask, x&(~y|~w|~z)
//     - sweep_cnt_width()  : width of the settle counter for a given SETTLE
// -----------------------------------------------------------------------------
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

  localparam int SWEEP_N_IN_DEFAULT = 4;

  // Bit i is the DUT output for input vector i (x = MSB).
  localparam logic [15:0] SWEEP_EXPECTED_DEFAULT = 16'h7F00;

  // The counter must be able to hold the value SETTLE; a zero-width counter
  // is not legal, so SETTLE of 0 or 1 still gets one bit.
  function automatic int sweep_cnt_width(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_settle_counter
//   Hold counter that keeps each vector on the DUT inputs for SETTLE idle
//   cycles before the response is sampled.
//
//   Parameters:
//     SETTLE : number of idle cycles before tick (0 = tick immediately)
//   Ports:
//     clk   in  clock, rising edge
//     rst_n in  asynchronous active-low reset
//     clr   in  return count to 0 (wins over en)
//     en    in  count up while below SETTLE
//     tick  out count == SETTLE
// -----------------------------------------------------------------------------
module truth_table_sweeper_settle_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = sweep_cnt_width(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_MAX);

  // Saturates at SETTLE so the tick stays asserted until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//   Drives an N_IN-input combinational DUT through all 2^N_IN input vectors
//   in ascending order (x on the MSB), holds each vector SETTLE+1 cycles,
//   captures the DUT response into a truth table and compares it against the
//   EXPECTED minterm mask.
//
//   Optional build macro:
//     SWEEP_STOP_ON_ERR_EN : when defined, the first mismatching sample ends
//                            the sweep; unvisited table bits stay 0.
//
//   Parameters:
//     N_IN     : number of DUT inputs
//     SETTLE   : idle cycles between driving a vector and sampling it
//     EXPECTED : expected truth table, bit i = output for vector i
//   Ports:
//     clk           in   clock, rising edge
//     rst_n         in   asynchronous active-low reset
//     start         in   request a sweep (only looked at in IDLE)
//     resp_in       in   DUT output
//     vec_out       out  DUT input vector, bit N_IN-1 = x
//     busy          out  sweep in progress
//     done          out  one-cycle pulse at sweep end
//     table_out     out  captured truth table
//     mismatch      out  sticky: some sample differed from EXPECTED
//     err_count     out  number of mismatching vectors
//     first_err_idx out  vector index of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                      N_IN     = SWEEP_N_IN_DEFAULT,
  parameter int                      SETTLE   = 1,
  parameter logic [(2**N_IN)-1:0]    EXPECTED = SWEEP_EXPECTED_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   resp_in,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   table_out,
  output logic                   mismatch,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_err_idx
);

  localparam int NVEC  = 2**N_IN;
  localparam int ERR_W = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  sweep_state_e      state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NVEC-1:0]   table_q, table_d;
  logic              mism_q, mism_d;
  logic [ERR_W-1:0]  errc_q, errc_d;
  logic [N_IN-1:0]   ferr_q, ferr_d;

  logic              cnt_clr;
  logic              cnt_en;
  logic              tick;
  logic              bit_err;
  logic              end_sweep;

  truth_table_sweeper_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    table_d   = table_q;
    mism_d    = mism_q;
    errc_d    = errc_q;
    ferr_d    = ferr_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    bit_err   = 1'b0;
    end_sweep = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          table_d = '0;
          mism_d  = 1'b0;
          errc_d  = '0;
          ferr_d  = '0;
          vec_d   = '0;
          busy_d  = 1'b1;
          cnt_clr = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        cnt_en = 1'b1;
        if (tick) begin
          // An X/Z response is stored as-is and does not count as an error.
          table_d[vec_q] = resp_in;
          bit_err        = (resp_in != EXPECTED[vec_q]);
          if (bit_err) begin
            errc_d = errc_q + ERR_W'(1);
            mism_d = 1'b1;
            if (!mism_q) begin
              ferr_d = vec_q;
            end
          end
`ifdef SWEEP_STOP_ON_ERR_EN
          end_sweep = (vec_q == LAST_VEC) || bit_err;
`else
          end_sweep = (vec_q == LAST_VEC);
`endif
          if (end_sweep) begin
            // vec_out keeps the last vector applied.
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cnt_clr = 1'b1;
          end
        end
      end

      DONE: begin
        // done is registered, so the pulse appears as the FSM re-enters IDLE;
        // start is not looked at here.
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      mism_q  <= 1'b0;
      errc_q  <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      mism_q  <= mism_d;
      errc_q  <= errc_d;
      ferr_q  <= ferr_d;
    end
  end

  assign vec_out       = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign table_out     = table_q;
  assign mismatch      = mism_q;
  assign err_count     = errc_q;
  assign first_err_idx = ferr_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//   Three sweeper instances (SETTLE = 1, 3, 0) share one behavioural DUT
//   model whose behaviour is selected by 'mode':
//     0 = x&(~y|~w|~z), 1 = stuck at 0, 2 = inverted, 3 = stuck at 1.
//   Honours SWEEP_STOP_ON_ERR_EN when the build defines it.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  typedef struct {
    int          sel;    // which instance
    int          mode;   // DUT behaviour
    logic [15:0] tbl;
    logic [4:0]  err;
    logic [3:0]  first;
    logic        mism;
    int          lat;    // edges from start edge to done visible
  } row_t;

  localparam int SETTLE_OF [3] = '{1, 3, 0};
  localparam int NROWS = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  int          mode;

  logic        start_v [3];
  logic        resp_v  [3];
  logic [3:0]  vec_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] tbl_v   [3];
  logic        mis_v   [3];
  logic [4:0]  ec_v    [3];
  logic [3:0]  fe_v    [3];

  int   checks = 0;
  int   errors = 0;
  row_t rows [NROWS];
  row_t exp_q [$];

  always #5 clk = ~clk;

  function automatic logic model(input int m, input logic [3:0] v);
    logic f;
    f = v[3] & ~(v[2] & v[1] & v[0]);
    case (m)
      0:       return f;
      1:       return 1'b0;
      2:       return ~f;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      resp_v[i] = model(mode, vec_v[i]);
    end
  end

  truth_table_sweeper #(.N_IN(4), .SETTLE(1), .EXPECTED(16'h7F00)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .resp_in(resp_v[0]),
    .vec_out(vec_v[0]), .busy(busy_v[0]), .done(done_v[0]), .table_out(tbl_v[0]),
    .mismatch(mis_v[0]), .err_count(ec_v[0]), .first_err_idx(fe_v[0]));

  truth_table_sweeper #(.N_IN(4), .SETTLE(3), .EXPECTED(16'h7F00)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .resp_in(resp_v[1]),
    .vec_out(vec_v[1]), .busy(busy_v[1]), .done(done_v[1]), .table_out(tbl_v[1]),
    .mismatch(mis_v[1]), .err_count(ec_v[1]), .first_err_idx(fe_v[1]));

  truth_table_sweeper #(.N_IN(4), .SETTLE(0), .EXPECTED(16'h7F00)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .resp_in(resp_v[2]),
    .vec_out(vec_v[2]), .busy(busy_v[2]), .done(done_v[2]), .table_out(tbl_v[2]),
    .mismatch(mis_v[2]), .err_count(ec_v[2]), .first_err_idx(fe_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs(input int s);
    return {busy_v[s], done_v[s], mis_v[s], vec_v[s], tbl_v[s], ec_v[s], fe_v[s]};
  endfunction

  task automatic run_row(input int r);
    row_t rw;
    row_t e;
    int   s;
    int   n;
    bit   got;
    bit   vec_ok;
    rw   = rows[r];
    s    = rw.sel;
    mode = rw.mode;
    exp_q.push_back(rw);

    @(negedge clk);
    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    start_v[s] = 1'b0;
    check($sformatf("r%0d_busy_start", r), {vec_v[s], busy_v[s]}, {4'd0, 1'b1});

    n = 0;
    got = 1'b0;
    vec_ok = 1'b1;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (done_v[s]) begin
        got = 1'b1;
      end else if (n < rw.lat - 1 && vec_v[s] !== 4'(n / (SETTLE_OF[s] + 1))) begin
        vec_ok = 1'b0;
      end
    end

    e = exp_q.pop_front();
    check($sformatf("r%0d_done_seen", r), 32'(got), 32'd1);
    check($sformatf("r%0d_vec_seq", r), 32'(vec_ok), 32'd1);
    check($sformatf("r%0d_latency", r), n, e.lat);
    check($sformatf("r%0d_table", r), tbl_v[s], e.tbl);
    check($sformatf("r%0d_err_count", r), ec_v[s], e.err);
    check($sformatf("r%0d_first_err", r), fe_v[s], e.first);
    check($sformatf("r%0d_mismatch", r), mis_v[s], e.mism);
    check($sformatf("r%0d_busy_end", r), busy_v[s], 1'b0);

    @(posedge clk);
    #1;
    check($sformatf("r%0d_done_pulse", r), done_v[s], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("r%0d_hold", r), {tbl_v[s], ec_v[s], fe_v[s], mis_v[s]},
          {e.tbl, e.err, e.first, e.mism});
  endtask

  initial begin
    int n;
    int first_done;
    int second_done;
    bit busy_seen;
    bit done_in_rst;

    // sel, mode, table, err, first, mismatch, latency
    rows[0] = '{0, 0, 16'h7F00, 5'd0,  4'd0, 1'b0, 33};
    rows[4] = '{1, 0, 16'h7F00, 5'd0,  4'd0, 1'b0, 65};
    rows[5] = '{2, 0, 16'h7F00, 5'd0,  4'd0, 1'b0, 17};
`ifdef SWEEP_STOP_ON_ERR_EN
    rows[1] = '{0, 1, 16'h0000, 5'd1,  4'd8, 1'b1, 19};
    rows[2] = '{0, 2, 16'h0001, 5'd1,  4'd0, 1'b1, 3};
    rows[3] = '{0, 3, 16'h0001, 5'd1,  4'd0, 1'b1, 3};
    rows[6] = '{2, 2, 16'h0001, 5'd1,  4'd0, 1'b1, 2};
`else
    rows[1] = '{0, 1, 16'h0000, 5'd7,  4'd8, 1'b1, 33};
    rows[2] = '{0, 2, 16'h80FF, 5'd16, 4'd0, 1'b1, 33};
    rows[3] = '{0, 3, 16'hFFFF, 5'd9,  4'd0, 1'b1, 33};
    rows[6] = '{2, 2, 16'h80FF, 5'd16, 4'd0, 1'b1, 17};
`endif

    mode  = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_outputs_%0d", i), all_outs(i), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int r = 0; r < NROWS; r++) begin
      run_row(r);
    end

    // start held high: ignored while busy/DONE, re-accepted from IDLE.
    mode = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    n = 0;
    first_done = 0;
    second_done = 0;
    busy_seen = 1'b0;
    while (second_done == 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (first_done != 0 && n == first_done + 1) begin
        busy_seen = busy_v[0] && (vec_v[0] == 4'd0);
      end
      if (done_v[0]) begin
        if (first_done == 0) first_done = n;
        else second_done = n;
      end
    end
    @(negedge clk);
    start_v[0] = 1'b0;
    check("held_first_done", first_done - 1, 33);
    check("held_restart_busy", 32'(busy_seen), 32'd1);
    check("held_second_done", second_done - 1, 67);
    check("held_table", tbl_v[0], 16'h7F00);
    repeat (3) @(posedge clk);

    // Reset mid-sweep: asynchronous abort, no done pulse.
    mode = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy_before_rst", {busy_v[0], tbl_v[0][8]}, 2'b11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", all_outs(0), 32'd0);
    done_in_rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done_v[0] || busy_v[0]) done_in_rst = 1'b1;
    end
    check("mid_rst_no_done", 32'(done_in_rst), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_row(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
